matrix_alu: RTL and testbench
=============================

MATRIX_ALU -- requirements
Module: matrix_alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low (sampled on rising clk; 0 = reset).
REQ-003 en_alu  input  1  command strobe from the execution engine; only a value of 1'b1 counts as asserted, and X/Z counts as deasserted.
REQ-004 op  input  3  opcode, sampled with en_alu.
REQ-005 s1  input  4  first source matrix slot.
REQ-006 s2  input  8  second source slot in bits [3:0], or unsigned immediate for SCALE.
REQ-007 dest  input  4  destination matrix slot.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high from command acceptance through the done cycle.
REQ-010 err  output  1  illegal-opcode flag, valid with done.
REQ-011 wr_en / wr_addr[7:0] / wr_data[15:0]  input  preload port; wr_addr = {slot[3:0], row[1:0], col[1:0]}.
REQ-012 rd_addr[7:0] input, rd_data[15:0] output  readback port, same address format as wr_addr.

Function
REQ-013 The block SHALL store 16 matrix slots, each a 4x4 array of 16-bit two's-complement elements.
REQ-014 The block SHALL implement these states: IDLE, EXEC, COMMIT, DONE.
REQ-015 In IDLE, when en_alu=1 at a rising edge, the block SHALL latch op, s1, s2 and dest, set busy=1, clear err, clear the element counter, and enter EXEC.
REQ-016 The block SHALL ignore en_alu while not in IDLE: no latch and no queueing.
REQ-017 Opcodes SHALL be:
- 001 ADD: M[dest] = M[s1] + M[s2[3:0]].
- 010 SUB: M[dest] = M[s1] - M[s2[3:0]].
- 011 SCALE: M[dest] = M[s1] * zero-extended s2.
- 100 MUL: M[dest] = M[s1] x M[s2[3:0]], a 4x4 matrix product.
- 101 TRANSPOSE: M[dest] = M[s1] transposed.
REQ-018 Opcode 000 SHALL be a NOP: zero EXEC cycles, then COMMIT with no write, then DONE with err=0.
REQ-019 Opcodes 110 and 111 SHALL follow the NOP path but set err=1 in the DONE cycle.
REQ-020 All arithmetic SHALL be modulo 2^16: sums, differences and products are truncated to their low 16 bits, and the MUL accumulator is 16 bits wide and wraps.
REQ-021 In EXEC, ADD, SUB, SCALE and TRANSPOSE SHALL produce one element per cycle in row-major order, taking 16 cycles.
REQ-022 In EXEC, MUL SHALL perform one multiply-accumulate per cycle, taking 64 cycles: the inner index k (0..3) varies fastest, and the accumulator clears at k=0.
REQ-023 EXEC results SHALL go to a 16-element staging buffer; source slots SHALL NOT be modified during EXEC.
REQ-024 COMMIT SHALL write the whole staging buffer to M[dest] in one cycle, so dest may equal s1 and/or s2 with correct, alias-free results.
REQ-025 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE, where busy=0.
REQ-026 Latency SHALL be measured from the accept edge N:
- elementwise ops: done high in cycle N+18;
- MUL: done high in cycle N+66;
- NOP and illegal opcodes: done high in cycle N+2.
REQ-027 err SHALL hold its value until the next accepted command.
REQ-028 The preload write SHALL take effect only in IDLE; a wr_en pulse in any other state SHALL be dropped silently.
REQ-029 If wr_en and en_alu arrive in the same IDLE cycle, the write SHALL land first, and the command SHALL see the written value.
REQ-030 rd_data SHALL be registered: it reflects M[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-031 rd_data SHALL show M[dest] updated from the cycle after COMMIT.

Reset
REQ-032 On rst=0 at a rising edge, the block SHALL force: state=IDLE; done=0; busy=0; err=0; rd_data=0; all slots, the staging buffer, the counters and the accumulator set to 0.
REQ-033 A reset asserted mid-EXEC or in COMMIT SHALL abort the command with no write to dest and no done pulse.
REQ-034 en_alu SHALL be ignored in the first cycle after reset releases only if rst was still 0 at that edge; otherwise normal acceptance applies.

Verification
REQ-035 ADD: preload M1 all elements 5 and M0 all elements 3; op=001, s1=1, s2=0x00, dest=2 -> done at N+18, err=0, and every M2 element = 8.
REQ-036 SCALE with wrap: M4[i] = 0x4000; op=011, s1=4, s2=0x07, dest=5 -> every M5 element = 0xC000 (low 16 bits of 0x1C000).
REQ-037 MUL with aliasing: M5 = identity, M4[r][c] = 4r+c; op=100, s1=5, s2=0x04, dest=5 -> done at N+66, and M5[r][c] = 4r+c.
REQ-038 TRANSPOSE in place: M2[r][c] = 4r+c; op=101, s1=2, dest=2 -> M2[r][c] = 4c+r.
REQ-039 Illegal opcode and busy behaviour: op=110 -> done at N+2 with err=1. Then a MUL with en_alu and wr_en pulsed at N+10 -> second command ignored, write dropped, and exactly one done.
REQ-040 Reset mid-op: start ADD into slot 3, drive rst=0 at N+8 -> no done, busy=0, and M3 = 0.

Source files
------------

// File: rtl/matrix_alu_if.sv
interface matrix_alu_if;
  logic       en_alu;
  logic [2:0] op;
  logic [3:0] s1;
  logic [7:0] s2;
  logic [3:0] dest;
  logic       done;
  logic       busy;
  logic       err;

  modport master (
    output en_alu, op, s1, s2, dest,
    input  done, busy, err
  );

  modport slave (
    input  en_alu, op, s1, s2, dest,
    output done, busy, err
  );
endinterface

// File: rtl/matrix_alu.sv
module matrix_alu (
  input  logic        clk,
  input  logic        rst,
  matrix_alu_if.slave cmd,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_COMMIT,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_ADD       = 3'b001,
    OP_SUB       = 3'b010,
    OP_SCALE     = 3'b011,
    OP_MUL       = 3'b100,
    OP_TRANSPOSE = 3'b101,
    OP_ILL6      = 3'b110,
    OP_ILL7      = 3'b111
  } op_e;

  state_e      r_state;
  op_e         r_op;
  logic [3:0]  r_s1;
  logic [7:0]  r_s2;
  logic [3:0]  r_dest;
  logic [5:0]  r_cnt;
  logic [15:0] r_acc;
  logic        r_done;
  logic        r_busy;
  logic        r_err;
  logic [15:0] r_rd_data;
  logic [15:0] r_mem   [0:15][0:15];
  logic [15:0] r_stage [0:15];

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_elem;
  logic [15:0] w_ma;
  logic [15:0] w_mb;
  logic [15:0] w_mac;
  logic        w_accept;
  logic        w_cmd_compute;
  logic        w_writes;
  logic        w_last;

  // Only a clean 1 accepts a command; X/Z on en_alu is treated as idle.
  assign w_accept      = (cmd.en_alu === 1'b1);
  assign w_cmd_compute = (cmd.op >= 3'b001) && (cmd.op <= 3'b101);
  assign w_writes      = (r_op >= OP_ADD) && (r_op <= OP_TRANSPOSE);
  assign w_last        = (r_op == OP_MUL) ? (r_cnt == 6'd63) : (r_cnt == 6'd15);

  always_comb begin
    w_a    = r_mem[r_s1][r_cnt[3:0]];
    w_b    = r_mem[r_s2[3:0]][r_cnt[3:0]];
    w_elem = '0;
    case (r_op)
      OP_ADD:       w_elem = w_a + w_b;
      OP_SUB:       w_elem = w_a - w_b;
      OP_SCALE:     w_elem = w_a * {8'h00, r_s2};
      OP_TRANSPOSE: w_elem = r_mem[r_s1][{r_cnt[1:0], r_cnt[3:2]}];
      default:      w_elem = '0;
    endcase
  end

  // MUL counter layout is {row, col, k}; k runs fastest and restarts the accumulator.
  always_comb begin
    w_ma  = r_mem[r_s1][{r_cnt[5:4], r_cnt[1:0]}];
    w_mb  = r_mem[r_s2[3:0]][{r_cnt[1:0], r_cnt[3:2]}];
    w_mac = ((r_cnt[1:0] == 2'd0) ? 16'h0000 : r_acc) + w_ma * w_mb;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_s1      <= '0;
      r_s2      <= '0;
      r_dest    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      for (int unsigned s = 0; s < 16; s++) begin
        r_stage[4'(s)] <= '0;
        for (int unsigned e = 0; e < 16; e++) begin
          r_mem[4'(s)][4'(e)] <= '0;
        end
      end
    end else begin
      r_rd_data <= r_mem[rd_addr[7:4]][rd_addr[3:0]];
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wr_en) begin
            r_mem[wr_addr[7:4]][wr_addr[3:0]] <= wr_data;
          end
          if (w_accept) begin
            r_op    <= op_e'(cmd.op);
            r_s1    <= cmd.s1;
            r_s2    <= cmd.s2;
            r_dest  <= cmd.dest;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= w_cmd_compute ? ST_EXEC : ST_COMMIT;
          end
        end
        ST_EXEC: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_mac;
            if (r_cnt[1:0] == 2'd3) begin
              r_stage[r_cnt[5:2]] <= w_mac;
            end
          end else begin
            r_stage[r_cnt[3:0]] <= w_elem;
          end
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (w_writes) begin
            for (int unsigned e = 0; e < 16; e++) begin
              r_mem[r_dest][4'(e)] <= r_stage[4'(e)];
            end
          end
          r_done  <= 1'b1;
          r_err   <= (r_op == OP_ILL6) || (r_op == OP_ILL7);
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd.done = r_done;
  assign cmd.busy = r_busy;
  assign cmd.err  = r_err;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_matrix_alu.sv
module tb_matrix_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;

  matrix_alu_if bus();

  matrix_alu dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   accept;
    int   lat;
    logic err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mm [16][16];
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  int          n_exp_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_latency", 32'(cyc + 1 - e.accept), 32'(e.lat));
        chk("err_at_done", {31'd0, bus.err}, {31'd0, e.err});
        chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  // Reference model: whole-matrix operations on the bench copy of memory.
  function automatic void apply_model(input logic [2:0] op, input logic [3:0] a,
                                      input logic [7:0] b, input logic [3:0] d);
    logic [15:0] res [16];
    logic [3:0]  bs;
    longint      acc;
    bs = b[3:0];
    if (op == 3'd0 || op > 3'd5) return;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (op)
          3'd1: res[r*4+c] = mm[a][r*4+c] + mm[bs][r*4+c];
          3'd2: res[r*4+c] = mm[a][r*4+c] - mm[bs][r*4+c];
          3'd3: res[r*4+c] = 16'(longint'(mm[a][r*4+c]) * longint'(b));
          3'd4: begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc += longint'(mm[a][r*4+k]) * longint'(mm[bs][k*4+c]);
            res[r*4+c] = 16'(acc);
          end
          default: res[r*4+c] = mm[a][c*4+r];
        endcase
      end
    end
    for (int i = 0; i < 16; i++) mm[d][i] = res[i];
  endfunction

  function automatic int latency_of(input logic [2:0] op);
    if (op == 3'd0 || op > 3'd5) return 2;
    if (op == 3'd4) return 66;
    return 18;
  endfunction

  task automatic preload(input int slot, input int idx, input logic [15:0] val);
    wr_en   = 1'b1;
    wr_addr = 8'((slot << 4) | idx);
    wr_data = val;
    mm[slot][idx] = val;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill(input int slot, input int mode, input logic [15:0] val);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: preload(slot, i, val);
        1: preload(slot, i, 16'(i));
        2: preload(slot, i, ((i / 4) == (i % 4)) ? 16'd1 : 16'd0);
        default: preload(slot, i, 16'($urandom));
      endcase
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [7:0] b,
                       input logic [3:0] d);
    exp_t e;
    bus.en_alu = 1'b1;
    bus.op     = op;
    bus.s1     = a;
    bus.s2     = b;
    bus.dest   = d;
    e.accept   = cyc + 1;
    e.lat      = latency_of(op);
    e.err      = (op > 3'd5);
    apply_model(op, a, b, d);
    sb.push_back(e);
    n_exp_done++;
    @(negedge clk);
    bus.en_alu = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
      n_exp_done -= sb.size();
      sb.delete();
    end
    @(negedge clk);
    chk({nm, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic read_check(input string nm, input int slot, input int idx);
    rd_addr = 8'((slot << 4) | idx);
    @(negedge clk);
    chk(nm, {16'd0, rd_data}, {16'd0, mm[slot][idx]});
  endtask

  task automatic check_slot(input string nm, input int slot);
    for (int i = 0; i < 16; i++) read_check(nm, slot, i);
  endtask

  initial begin
    int done_before;
    logic [2:0] rop;
    logic [3:0] ra, rd;
    logic [7:0] rb;

    rst        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    bus.en_alu = 1'b0;
    bus.op     = '0;
    bus.s1     = '0;
    bus.s2     = '0;
    bus.dest   = '0;
    for (int s = 0; s < 16; s++) for (int i = 0; i < 16; i++) mm[s][i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    @(negedge clk);

    // ADD
    fill(1, 0, 16'd5);
    fill(0, 0, 16'd3);
    issue(3'b001, 4'd1, 8'h00, 4'd2);
    wait_done("add");
    check_slot("add_m2", 2);

    // SCALE with wrap
    fill(4, 0, 16'h4000);
    issue(3'b011, 4'd4, 8'h07, 4'd5);
    wait_done("scale");
    check_slot("scale_m5", 5);

    // MUL with dest aliasing s1
    fill(5, 2, 16'd0);
    fill(4, 1, 16'd0);
    issue(3'b100, 4'd5, 8'h04, 4'd5);
    wait_done("mul_alias");
    check_slot("mul_m5", 5);

    // TRANSPOSE in place
    fill(2, 1, 16'd0);
    issue(3'b101, 4'd2, 8'h00, 4'd2);
    wait_done("transpose");
    check_slot("transpose_m2", 2);

    // Illegal opcode, err hold, then command+write while busy
    issue(3'b110, 4'd0, 8'h00, 4'd0);
    wait_done("illegal");
    repeat (3) @(negedge clk);
    chk("err_hold", {31'd0, bus.err}, 32'd1);
    fill(6, 3, 16'd0);
    issue(3'b100, 4'd5, 8'h04, 4'd6);
    chk("err_clear_on_accept", {31'd0, bus.err}, 32'd0);
    repeat (9) @(negedge clk);
    bus.en_alu = 1'b1;
    bus.op     = 3'b001;
    bus.dest   = 4'd7;
    wr_en      = 1'b1;
    wr_addr    = 8'h70;
    wr_data    = 16'hBEEF;
    @(negedge clk);
    bus.en_alu = 1'b0;
    wr_en      = 1'b0;
    wait_done("busy_ignore");
    repeat (4) @(negedge clk);
    check_slot("busy_mul_m6", 6);
    read_check("busy_write_dropped", 7, 0);

    // Write and command in the same IDLE cycle
    wr_en   = 1'b1;
    wr_addr = 8'h13;
    wr_data = 16'h1234;
    mm[1][3] = 16'h1234;
    issue(3'b010, 4'd1, 8'h00, 4'd8);
    wr_en = 1'b0;
    wait_done("same_cycle");
    check_slot("same_cycle_m8", 8);

    // Randomized commands, X on en_alu while idle
    for (int s = 0; s < 16; s++) fill(s, 3, 16'd0);
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.en_alu = 1'bx;
        repeat (2) @(negedge clk);
        bus.en_alu = 1'b0;
      end
      for (int p = 0; p < 3; p++) preload($urandom_range(0, 15), $urandom_range(0, 15), 16'($urandom));
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      rb  = 8'($urandom_range(0, 255));
      rd  = 4'($urandom_range(0, 15));
      issue(rop, ra, rb, rd);
      wait_done("rand");
      check_slot("rand_dest", int'(rd));
    end

    // Reset mid-op aborts
    issue(3'b001, 4'd1, 8'h00, 4'd3);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    done_before = n_done;
    n_exp_done -= sb.size();
    sb.delete();
    for (int s = 0; s < 16; s++) for (int i = 0; i < 16; i++) mm[s][i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'(done_before));
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_slot("abort_m3", 3);

    chk("done_count", 32'(n_done), 32'(n_exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
